servo_pwm_decoder: RTL and testbench



---
 rtl/servo_pwm_decoder.sv | 186 ++++++++++++++++++
 tb/tb_servo_pwm_decoder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_decoder.sv
// Hobby-servo PWM reader: conditions the input, measures pulse width and period,
// and converts width to an angle with a degree counter instead of a divider.
module servo_pwm_decoder #(
  parameter int unsigned GLITCH_CYCLES    = 3,
  parameter int unsigned MIN_PULSE_CYCLES = 50000,
  parameter int unsigned CYCLES_PER_DEG   = 278,
  parameter int unsigned MAX_ANGLE        = 180,
  parameter int unsigned RUNT_CYCLES      = 25000,
  parameter int unsigned MAX_PULSE_CYCLES = 125000,
  parameter int unsigned TIMEOUT_CYCLES   = 1500000,
  parameter int unsigned RESET_ANGLE      = 90
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        pwm_in,
  output logic [7:0]  angle,
  output logic        angle_valid,
  output logic [16:0] pulse_width,
  output logic [20:0] period,
  output logic        pulse_error,
  output logic        signal_lost
);

  localparam int unsigned ANGLE_W  = 8;
  localparam int unsigned WIDTH_W  = 17;
  localparam int unsigned PERIOD_W = 21;
  localparam int unsigned GF_W     = $clog2(GLITCH_CYCLES + 1);
  localparam int unsigned LOW_RUN  = GLITCH_CYCLES + 2;
  localparam int unsigned LR_W     = $clog2(LOW_RUN + 1);
  localparam int unsigned DEG_W    = $clog2(CYCLES_PER_DEG + 1);
  localparam int unsigned TO_W     = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {WAIT_LOW, IDLE, HIGH} state_t;

  logic [1:0]      sync_q;
  logic            filt, filt_d;
  logic [GF_W-1:0] gf_cnt;
  logic [LR_W-1:0] low_run;
  logic            rise, fall;

  state_t                state, state_nxt;
  logic [WIDTH_W-1:0]    width_cnt, width_nxt, pw_nxt;
  logic [DEG_W-1:0]      deg_cnt, deg_nxt;
  logic [ANGLE_W-1:0]    acc, acc_nxt, angle_nxt;
  logic [PERIOD_W-1:0]   per_cnt, per_nxt, period_nxt;
  logic                  seen_rise, seen_nxt;
  logic [TO_W-1:0]       to_cnt, to_nxt;
  logic                  valid_nxt, err_nxt, lost_nxt;

  // Synchronizer, glitch filter, and a run of true lows; the low run ignores the
  // two reset-zero synchronizer stages so a pin held high across reset is not
  // mistaken for a completed low.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync_q  <= 2'b00;
      filt    <= 1'b0;
      filt_d  <= 1'b0;
      gf_cnt  <= '0;
      low_run <= '0;
    end else begin
      sync_q <= {sync_q[0], pwm_in};
      filt_d <= filt;
      if (sync_q[1] == filt) begin
        gf_cnt <= '0;
      end else if (gf_cnt == GF_W'(GLITCH_CYCLES - 1)) begin
        filt   <= sync_q[1];
        gf_cnt <= '0;
      end else begin
        gf_cnt <= gf_cnt + GF_W'(1);
      end
      if (sync_q[1]) begin
        low_run <= '0;
      end else if (low_run != LR_W'(LOW_RUN)) begin
        low_run <= low_run + LR_W'(1);
      end
    end
  end

  assign rise = filt & ~filt_d;
  assign fall = ~filt & filt_d;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state       <= WAIT_LOW;
      width_cnt   <= '0;
      deg_cnt     <= '0;
      acc         <= '0;
      per_cnt     <= '0;
      seen_rise   <= 1'b0;
      to_cnt      <= '0;
      angle       <= ANGLE_W'(RESET_ANGLE);
      pulse_width <= '0;
      period      <= '0;
      angle_valid <= 1'b0;
      pulse_error <= 1'b0;
      signal_lost <= 1'b1;
    end else begin
      state       <= state_nxt;
      width_cnt   <= width_nxt;
      deg_cnt     <= deg_nxt;
      acc         <= acc_nxt;
      per_cnt     <= per_nxt;
      seen_rise   <= seen_nxt;
      to_cnt      <= to_nxt;
      angle       <= angle_nxt;
      pulse_width <= pw_nxt;
      period      <= period_nxt;
      angle_valid <= valid_nxt;
      pulse_error <= err_nxt;
      signal_lost <= lost_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    width_nxt  = width_cnt;
    deg_nxt    = deg_cnt;
    acc_nxt    = acc;
    angle_nxt  = angle;
    pw_nxt     = pulse_width;
    valid_nxt  = 1'b0;
    err_nxt    = 1'b0;
    per_nxt    = per_cnt;
    period_nxt = period;
    seen_nxt   = seen_rise;
    to_nxt     = to_cnt;
    lost_nxt   = signal_lost;

    case (state)
      WAIT_LOW: begin
        if (!filt && low_run == LR_W'(LOW_RUN)) state_nxt = IDLE;
      end
      IDLE: begin
        if (rise) begin
          width_nxt = WIDTH_W'(1);
          deg_nxt   = '0;
          acc_nxt   = '0;
          state_nxt = HIGH;
        end
      end
      HIGH: begin
        if (fall) begin
          if (width_cnt < WIDTH_W'(RUNT_CYCLES)) begin
            err_nxt = 1'b1;
          end else begin
            angle_nxt = acc;
            pw_nxt    = width_cnt;
            valid_nxt = 1'b1;
          end
          state_nxt = IDLE;
        end else if (width_cnt >= WIDTH_W'(MAX_PULSE_CYCLES)) begin
          err_nxt   = 1'b1;
          state_nxt = WAIT_LOW;
        end else begin
          width_nxt = width_cnt + WIDTH_W'(1);
          // One degree per CYCLES_PER_DEG cycles beyond the 0-degree width.
          if (width_cnt >= WIDTH_W'(MIN_PULSE_CYCLES)) begin
            if (deg_cnt == DEG_W'(CYCLES_PER_DEG - 1)) begin
              deg_nxt = '0;
              if (acc != ANGLE_W'(MAX_ANGLE)) acc_nxt = acc + ANGLE_W'(1);
            end else begin
              deg_nxt = deg_cnt + DEG_W'(1);
            end
          end
        end
      end
      default: state_nxt = WAIT_LOW;
    endcase

    // Period and timeout count the rise cycle as 1; a rise beats a timeout.
    if (rise) begin
      if (seen_rise) period_nxt = per_cnt;
      per_nxt  = PERIOD_W'(1);
      seen_nxt = 1'b1;
      to_nxt   = TO_W'(1);
    end else begin
      if (seen_rise && per_cnt != '1) per_nxt = per_cnt + PERIOD_W'(1);
      if (to_cnt != TO_W'(TIMEOUT_CYCLES)) begin
        to_nxt = to_cnt + TO_W'(1);
        if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) lost_nxt = 1'b1;
      end
    end
    if (valid_nxt) lost_nxt = 1'b0;
  end

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Directed bench for servo_pwm_decoder using scaled-down timing parameters.
module tb_servo_pwm_decoder;

  localparam int unsigned GL   = 3;
  localparam int unsigned MINP = 100;
  localparam int unsigned CPD  = 4;
  localparam int unsigned MAXA = 20;
  localparam int unsigned RUNT = 50;
  localparam int unsigned MAXP = 200;
  localparam int unsigned TO   = 3000;
  localparam int unsigned RA   = 10;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        pwm_in;
  logic [7:0]  angle;
  logic        angle_valid;
  logic [16:0] pulse_width;
  logic [20:0] period;
  logic        pulse_error;
  logic        signal_lost;

  int cyc = 0;
  int valid_cnt = 0, err_cnt = 0, valid_cyc = -1, err_cyc = -1;
  int errors = 0, checks = 0;
  int last_rise = 0;
  int vexp = 0, eexp = 0;
  int c0 = 0;

  int sw_w   [6] = '{100, 103, 104, 176, 180, 200};
  int sw_ang [6] = '{0, 0, 1, 19, 20, 20};

  servo_pwm_decoder #(
    .GLITCH_CYCLES(GL), .MIN_PULSE_CYCLES(MINP), .CYCLES_PER_DEG(CPD),
    .MAX_ANGLE(MAXA), .RUNT_CYCLES(RUNT), .MAX_PULSE_CYCLES(MAXP),
    .TIMEOUT_CYCLES(TO), .RESET_ANGLE(RA)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .pwm_in(pwm_in), .angle(angle),
    .angle_valid(angle_valid), .pulse_width(pulse_width), .period(period),
    .pulse_error(pulse_error), .signal_lost(signal_lost)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Strobe recorder, sampled mid-cycle.
  always @(negedge CLOCK_50) begin
    if (angle_valid) begin
      valid_cnt = valid_cnt + 1;
      valid_cyc = cyc;
    end
    if (pulse_error) begin
      err_cnt = err_cnt + 1;
      err_cyc = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic pulse(input int hi, input int lo);
    pwm_in = 1'b1;
    last_rise = cyc;
    tick(hi);
    pwm_in = 1'b0;
    tick(lo);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset  = 1'b1;
    pwm_in = 1'b0;
    tick(3);
    chk("rst_angle", 32'(angle), RA);
    chk("rst_width", 32'(pulse_width), 0);
    chk("rst_period", 32'(period), 0);
    chk("rst_valid", 32'(angle_valid), 0);
    chk("rst_error", 32'(pulse_error), 0);
    chk("rst_lost", 32'(signal_lost), 1);
    reset = 1'b0;
    tick(20);
    chk("pre_angle", 32'(angle), RA);
    chk("pre_lost", 32'(signal_lost), 1);

    // Nominal pulse train: width 150 -> angle 12, period 400.
    pulse(150, 250);
    vexp++;
    chk("nom_vcnt", valid_cnt, vexp);
    chk("nom_vcyc", valid_cyc, last_rise + 156);
    chk("nom_angle", 32'(angle), 12);
    chk("nom_width", 32'(pulse_width), 150);
    chk("nom_lost", 32'(signal_lost), 0);
    chk("nom_period1", 32'(period), 0);
    pulse(150, 250);
    pulse(150, 250);
    vexp += 2;
    chk("nom_vcnt3", valid_cnt, vexp);
    chk("nom_period", 32'(period), 400);
    chk("nom_angle3", 32'(angle), 12);

    // Width sweep including saturation and the maximum legal width.
    for (int i = 0; i < 6; i++) begin
      pulse(sw_w[i], 300);
      vexp++;
      chk($sformatf("sw_angle_w%0d", sw_w[i]), 32'(angle), sw_ang[i]);
      chk($sformatf("sw_width_w%0d", sw_w[i]), 32'(pulse_width), sw_w[i]);
      chk($sformatf("sw_vcnt_w%0d", sw_w[i]), valid_cnt, vexp);
    end
    chk("sw_errcnt", err_cnt, eexp);

    // Short-but-legal pulse, then runts around the runt boundary.
    pulse(60, 300);
    vexp++;
    chk("short_angle", 32'(angle), 0);
    chk("short_width", 32'(pulse_width), 60);
    pulse(104, 300);
    vexp++;
    chk("pre_runt_angle", 32'(angle), 1);
    pulse(20, 300);
    eexp++;
    chk("runt_errcnt", err_cnt, eexp);
    chk("runt_errcyc", err_cyc, last_rise + 26);
    chk("runt_vcnt", valid_cnt, vexp);
    chk("runt_angle", 32'(angle), 1);
    chk("runt_width", 32'(pulse_width), 104);
    pulse(49, 300);
    eexp++;
    chk("runt49_errcnt", err_cnt, eexp);
    pulse(50, 300);
    vexp++;
    chk("runt50_vcnt", valid_cnt, vexp);
    chk("runt50_width", 32'(pulse_width), 50);

    // Over-long pulse aborts at width MAXP+1, then the next pulse decodes.
    pulse(260, 300);
    eexp++;
    chk("long_errcnt", err_cnt, eexp);
    chk("long_errcyc", err_cyc, last_rise + 206);
    chk("long_vcnt", valid_cnt, vexp);
    pulse(150, 300);
    vexp++;
    chk("after_long_angle", 32'(angle), 12);
    chk("after_long_width", 32'(pulse_width), 150);

    // Two-cycle low blip inside a 162-cycle pulse must be filtered out.
    pwm_in = 1'b1;
    c0 = cyc;
    tick(60);
    pwm_in = 1'b0;
    tick(2);
    pwm_in = 1'b1;
    tick(100);
    pwm_in = 1'b0;
    tick(300);
    vexp++;
    chk("blip_vcnt", valid_cnt, vexp);
    chk("blip_width", 32'(pulse_width), 162);
    chk("blip_angle", 32'(angle), 15);
    chk("blip_errcnt", err_cnt, eexp);

    // Timeout: filtered rise at cycle c0+5, loss flagged exactly TO cycles later.
    chk("to_lost_before", 32'(signal_lost), 0);
    tick(c0 + 5 + TO - 1 - cyc);
    chk("to_lost_edge_m1", 32'(signal_lost), 0);
    tick(1);
    chk("to_lost_edge", 32'(signal_lost), 1);
    chk("to_angle_hold", 32'(angle), 15);

    // Reset in mid-pulse: immediate reset values, no partial report.
    pwm_in = 1'b1;
    tick(60);
    reset = 1'b1;
    #1;
    chk("mid_rst_angle", 32'(angle), RA);
    chk("mid_rst_width", 32'(pulse_width), 0);
    chk("mid_rst_period", 32'(period), 0);
    chk("mid_rst_lost", 32'(signal_lost), 1);
    tick(2);
    reset = 1'b0;
    tick(100);
    pwm_in = 1'b0;
    tick(300);
    chk("partial_vcnt", valid_cnt, vexp);
    chk("partial_angle", 32'(angle), RA);
    chk("partial_lost", 32'(signal_lost), 1);
    pulse(150, 300);
    vexp++;
    chk("post_rst_vcnt", valid_cnt, vexp);
    chk("post_rst_angle", 32'(angle), 12);
    chk("post_rst_width", 32'(pulse_width), 150);
    chk("post_rst_lost", 32'(signal_lost), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
